// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, data-memory wait with timeout, branch flush.
// Optional macro STALL_CNT_EN adds a saturating 32-bit count of cycles with the PC frozen.
module pipe_stall_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memRead_ID_EX,
  input  logic [4:0] destReg_ID_EX,
  input  logic [4:0] rs_IF_ID,
  input  logic [4:0] rt_IF_ID,
  input  logic       useRt_IF_ID,
  input  logic       branchTaken,
  input  logic       memReq_EX_MEM,
  input  logic       memAck,
  output logic       pcWr,
  output logic       regWr_IF_ID,
  output logic       regWr_ID_EX,
  output logic       regWr_EX_MEM,
  output logic       regWr_MEM_WB,
  output logic       flush_IF_ID,
  output logic       flush_ID_EX,
  output logic       memTimeout,
`ifdef STALL_CNT_EN
  output logic [31:0] stallCycles,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       load_use, mem_stall;
  logic [4:0] flow_en, en_c;
  logic [1:0] flow_fl, fl_c;
  logic       timeout_c;

  assign load_use  = memRead_ID_EX && (destReg_ID_EX != 5'd0) &&
                     ((destReg_ID_EX == rs_IF_ID) ||
                      (useRt_IF_ID && (destReg_ID_EX == rt_IF_ID)));
  assign mem_stall = memReq_EX_MEM && !memAck;

  // Enables/flushes once the memory condition is out of the way; load-use outranks branch.
  always_comb begin
    flow_en = 5'b11111;
    flow_fl = 2'b00;
    if (load_use) begin
      flow_en = 5'b00111;
      flow_fl = 2'b01;
    end else if (branchTaken) begin
      flow_fl = 2'b11;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    en_c       = 5'b00000;
    fl_c       = 2'b00;
    timeout_c  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          en_c = flow_en;
          fl_c = flow_fl;
        end
      end
      MEM_WAIT: begin
        if (memAck) begin
          en_c    = flow_en;
          fl_c    = flow_fl;
          state_d = RUN;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      HALT: timeout_c = 1'b1;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are forced low combinationally while reset is held.
  assign pcWr         = reset & en_c[4];
  assign regWr_IF_ID  = reset & en_c[3];
  assign regWr_ID_EX  = reset & en_c[2];
  assign regWr_EX_MEM = reset & en_c[1];
  assign regWr_MEM_WB = reset & en_c[0];
  assign flush_IF_ID  = reset & fl_c[1];
  assign flush_ID_EX  = reset & fl_c[0];
  assign memTimeout   = reset & timeout_c;
  assign state        = state_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pcWr && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: vector table, corner-case sequences and a random run
// against a behavioural model, with two instances (timeout 8 and timeout 4) sharing the inputs.
module tb_pipe_stall_ctrl;

  localparam logic [7:0] ALL_V  = 8'b1111_1000;
  localparam logic [7:0] LU_V   = 8'b0011_1010;
  localparam logic [7:0] BR_V   = 8'b1111_1110;
  localparam logic [7:0] HALT_V = 8'b0000_0001;
  localparam logic [7:0] FRZ_V  = 8'b0000_0000;

  logic       clk = 1'b0;
  logic       reset, memRead, useRt, br, memReq, memAck;
  logic [4:0] dest, rs, rt;
  logic [7:0] out8, out4;
  logic [1:0] state8, state4;
`ifdef STALL_CNT_EN
  logic [31:0] sc8, sc4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MEM_TIMEOUT(8), .CNT_W(8)) u8 (
    .clk(clk), .reset(reset), .memRead_ID_EX(memRead), .destReg_ID_EX(dest),
    .rs_IF_ID(rs), .rt_IF_ID(rt), .useRt_IF_ID(useRt), .branchTaken(br),
    .memReq_EX_MEM(memReq), .memAck(memAck),
    .pcWr(out8[7]), .regWr_IF_ID(out8[6]), .regWr_ID_EX(out8[5]),
    .regWr_EX_MEM(out8[4]), .regWr_MEM_WB(out8[3]), .flush_IF_ID(out8[2]),
    .flush_ID_EX(out8[1]), .memTimeout(out8[0]),
`ifdef STALL_CNT_EN
    .stallCycles(sc8),
`endif
    .state(state8));

  pipe_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) u4 (
    .clk(clk), .reset(reset), .memRead_ID_EX(memRead), .destReg_ID_EX(dest),
    .rs_IF_ID(rs), .rt_IF_ID(rt), .useRt_IF_ID(useRt), .branchTaken(br),
    .memReq_EX_MEM(memReq), .memAck(memAck),
    .pcWr(out4[7]), .regWr_IF_ID(out4[6]), .regWr_ID_EX(out4[5]),
    .regWr_EX_MEM(out4[4]), .regWr_MEM_WB(out4[3]), .flush_IF_ID(out4[2]),
    .flush_ID_EX(out4[1]), .memTimeout(out4[0]),
`ifdef STALL_CNT_EN
    .stallCycles(sc4),
`endif
    .state(state4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    memRead = 0; dest = 0; rs = 0; rt = 0; useRt = 0; br = 0; memReq = 0; memAck = 0;
  endtask

  task automatic do_reset();
    step();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out8", {24'd0, out8}, 32'd0);
    chk("reset_out4", {24'd0, out4}, 32'd0);
    chk("reset_state8", {30'd0, state8}, 32'd0);
    chk("reset_state4", {30'd0, state4}, 32'd0);
    step();
    reset = 1'b1;
  endtask

  // Behavioural model: per instance, a "waiting" flag, elapsed wait cycles and a halted flag.
  int  tmo[2] = '{8, 4};
  bit  m_wait[2], m_halt[2];
  int  m_cnt[2];
  longint m_sc[2];

  function automatic logic [7:0] mdl_out(input int i);
    bit lu, ms;
    lu = memRead && (dest != 0) && ((dest == rs) || (useRt && (dest == rt)));
    ms = memReq && !memAck;
    if (!reset) return FRZ_V;
    if (m_halt[i]) return HALT_V;
    if (m_wait[i]) begin
      if (!memAck) return FRZ_V;
    end else if (ms) return FRZ_V;
    if (lu) return LU_V;
    if (br) return BR_V;
    return ALL_V;
  endfunction

  function automatic int mdl_state(input int i);
    return m_halt[i] ? 2 : (m_wait[i] ? 1 : 0);
  endfunction

  task automatic mdl_reset(input int i);
    m_wait[i] = 0; m_halt[i] = 0; m_cnt[i] = 0; m_sc[i] = 0;
  endtask

  task automatic mdl_clock(input int i);
    logic [7:0] o;
    if (!reset) return;
    o = mdl_out(i);
    if (!o[7] && m_sc[i] < 64'hFFFF_FFFF) m_sc[i]++;
    if (m_halt[i]) begin
    end else if (m_wait[i]) begin
      if (memAck) m_wait[i] = 0;
      else begin
        m_cnt[i]++;
        if (m_cnt[i] == tmo[i]) begin m_halt[i] = 1; m_wait[i] = 0; end
      end
    end else if (memReq && !memAck) begin
      m_wait[i] = 1;
      m_cnt[i] = 0;
    end
  endtask

  typedef struct {
    logic       memRead;
    logic [4:0] dest, rs, rt;
    logic       useRt, br, memReq, memAck;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset = 1'b0;
    clear_inputs();

    vecs[0] = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ALL_V};
    vecs[1] = '{1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, LU_V};
    vecs[2] = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ALL_V};
    vecs[3] = '{1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, ALL_V};
    vecs[4] = '{1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, LU_V};
    vecs[5] = '{0, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0, BR_V};
    vecs[6] = '{1, 5'd9, 5'd9, 5'd2, 0, 1, 0, 0, LU_V};
    vecs[7] = '{0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, ALL_V};
    vecs[8] = '{0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, BR_V};
    vecs[9] = '{1, 5'd4, 5'd2, 5'd4, 1, 0, 1, 1, LU_V};

    do_reset();

    // Table: none of these vectors stalls memory, so both instances stay in RUN.
    for (int v = 0; v < 10; v++) begin
      memRead = vecs[v].memRead; dest = vecs[v].dest; rs = vecs[v].rs; rt = vecs[v].rt;
      useRt = vecs[v].useRt; br = vecs[v].br; memReq = vecs[v].memReq; memAck = vecs[v].memAck;
      @(negedge clk);
      chk($sformatf("vec%0d_out8", v), {24'd0, out8}, {24'd0, vecs[v].exp});
      chk($sformatf("vec%0d_out4", v), {24'd0, out4}, {24'd0, vecs[v].exp});
      chk($sformatf("vec%0d_state", v), {30'd0, state8}, 32'd0);
      step();
    end

    // Load-use: one bubble cycle, then the bubble has moved on and everything flows.
    do_reset();
    memRead = 1; dest = 5; rs = 5;
    @(negedge clk);
    chk("lu_bubble", {24'd0, out8}, {24'd0, LU_V});
    step();
    clear_inputs();
    @(negedge clk);
    chk("lu_after", {24'd0, out8}, {24'd0, ALL_V});

    // Memory handshake: 3 frozen cycles, then release on ack.
    do_reset();
    memReq = 1; memAck = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hs_frozen%0d", k), {24'd0, out8}, {24'd0, FRZ_V});
      chk($sformatf("hs_state%0d", k), {30'd0, state8}, (k == 0) ? 32'd0 : 32'd1);
      step();
    end
    memAck = 1;
    @(negedge clk);
    chk("hs_ack_out", {24'd0, out8}, {24'd0, ALL_V});
    chk("hs_ack_state", {30'd0, state8}, 32'd1);
    step();
    clear_inputs();
    @(negedge clk);
    chk("hs_back_run", {30'd0, state8}, 32'd0);

    // Timeout: the 4-cycle instance halts after 5 frozen cycles; the 8-cycle one accepts
    // an ack on its last wait cycle.
    do_reset();
    memReq = 1; memAck = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("to_frozen%0d", k), {24'd0, out4}, {24'd0, FRZ_V});
      step();
    end
    @(negedge clk);
    chk("to_halt_out", {24'd0, out4}, {24'd0, HALT_V});
    chk("to_halt_state", {30'd0, state4}, 32'd2);
    chk("to_u8_waiting", {30'd0, state8}, 32'd1);
    for (int k = 0; k < 3; k++) step();
    memAck = 1;
    @(negedge clk);
    chk("to_u8_last_ack", {24'd0, out8}, {24'd0, ALL_V});
    chk("to_u4_held", {24'd0, out4}, {24'd0, HALT_V});
    step();
    clear_inputs();
    @(negedge clk);
    chk("to_u8_run", {30'd0, state8}, 32'd0);
    chk("to_u4_sticky", {30'd0, state4}, 32'd2);
    step();
    #2 reset = 1'b0;
    #1;
    chk("to_async_state", {30'd0, state4}, 32'd0);
    chk("to_async_flag", {31'd0, out4[0]}, 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("to_after_reset", {24'd0, out4}, {24'd0, ALL_V});

    // Deferred branch: flush only when memory releases.
    do_reset();
    br = 1; memReq = 1; memAck = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("db_frozen%0d", k), {24'd0, out8}, {24'd0, FRZ_V});
      step();
    end
    memAck = 1;
    @(negedge clk);
    chk("db_release", {24'd0, out8}, {24'd0, BR_V});

`ifdef STALL_CNT_EN
    do_reset();
    memRead = 1; dest = 5; rs = 5;
    step();
    clear_inputs();
    memReq = 1;
    for (int k = 0; k < 3; k++) step();
    memAck = 1;
    step();
    clear_inputs();
    @(negedge clk);
    chk("sc_count", sc8, 32'd4);
    memReq = 1;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("sc_async_zero", sc8, 32'd0);
    chk("sc_async_state", {30'd0, state8}, 32'd0);
    step();
    reset = 1'b1;
    clear_inputs();
`endif

    // Random run against the model; starts from reset.
    step();
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset) mdl_reset(i);
        chk($sformatf("rand_out_t%0d", tmo[i]), {24'd0, (i == 0) ? out8 : out4},
            {24'd0, mdl_out(i)});
        chk($sformatf("rand_state_t%0d", tmo[i]), {30'd0, (i == 0) ? state8 : state4},
            mdl_state(i));
`ifdef STALL_CNT_EN
        chk($sformatf("rand_sc_t%0d", tmo[i]), (i == 0) ? sc8 : sc4, m_sc[i][31:0]);
`endif
        mdl_clock(i);
      end
      step();
      reset   = ($urandom_range(0, 39) != 0);
      memRead = $urandom_range(0, 1);
      dest    = 5'($urandom_range(0, 3));
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      useRt   = $urandom_range(0, 1);
      br      = ($urandom_range(0, 3) == 0);
      memReq  = $urandom_range(0, 1);
      memAck  = ($urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
